// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt dispatcher: FSM state encoding,
// source index constants, default timing parameters and a small helper
// that turns a source index into a one-hot irq vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_1    = 2'd1;
    localparam logic [1:0] SRC_2    = 2'd2;
    localparam logic [1:0] SRC_3    = 2'd3;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;
    localparam int unsigned HOLDOFF_DEFAULT = 2;

    // Source index (1..3) to one-hot bit position (bit0..bit2); none -> 0.
    function automatic logic [2:0] src_onehot(input logic [1:0] idx);
        logic [2:0] vec;
        vec = 3'b000;
        case (idx)
            SRC_1:   vec = 3'b001;
            SRC_2:   vec = 3'b010;
            SRC_3:   vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for the three interrupt sources. bit0 has the
// highest priority. The index uses the source numbering 1..3, 0 = none.
module irq_prio_enc
    import cpu_pkg::*;
(
    input  logic [2:0] req,
    output logic       valid,
    output logic [1:0] idx
);

    // Lowest set bit wins.
    always_comb begin
        valid = |req;
        idx   = SRC_NONE;
        if (req[0]) begin
            idx = SRC_1;
        end else if (req[1]) begin
            idx = SRC_2;
        end else if (req[2]) begin
            idx = SRC_3;
        end
    end

endmodule

// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: latches peripheral requests, applies a mask and
// fixed priority, and hands one request at a time to the core as a single
// cycle irq pulse, then waits for end-of-interrupt (or a service timeout)
// plus a holdoff gap before the next dispatch.
// Optional feature: define IRQ_OVERRUN_EN to add the sticky overrun port
// that flags requests arriving for an already pending or active source.
module irq_dispatcher
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] src_req,
    input  logic       mask_wr,
    input  logic [2:0] mask_data,
    input  logic       clr_err,
    input  logic       eirq,
    output logic       irq1,
    output logic       irq2,
    output logic       irq3,
    output logic [2:0] pending,
    output logic [1:0] active,
    output logic       busy,
    output logic       timeout_err
`ifdef IRQ_OVERRUN_EN
    ,
    output logic [2:0] overrun
`endif
);

    // Last counter value of a service window / holdoff window.
    localparam logic [15:0] SVC_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  HOLD_LAST = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

    state_t      state;
    logic [2:0]  mask;
    logic [2:0]  irq_vec;
    logic [15:0] svc_cnt;
    logic [3:0]  hold_cnt;

    logic [2:0]  eligible;
    logic        win_valid;
    logic [1:0]  win_idx;
    logic        dispatch;
    logic [2:0]  dispatch_clr;
    logic        timeout_hit;

    assign eligible = pending & mask;

    irq_prio_enc u_prio (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    assign dispatch     = (state == ST_IDLE) && win_valid;
    assign dispatch_clr = dispatch ? src_onehot(win_idx) : 3'b000;
    // eirq in the timeout cycle counts as a normal end of service.
    assign timeout_hit  = (state == ST_SERVICE) && !eirq && (svc_cnt == SVC_LAST);

    assign irq1 = irq_vec[0];
    assign irq2 = irq_vec[1];
    assign irq3 = irq_vec[2];

    // Request latch: new requests are OR-ed in after the dispatch clear so
    // a request for the winner in its dispatch cycle stays pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 3'b000;
        end else begin
            pending <= (pending & ~dispatch_clr) | src_req;
        end
    end

    // Mask register; all sources enabled out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= 3'b111;
        end else if (mask_wr) begin
            mask <= mask_data;
        end
    end

    // Dispatch FSM with registered irq, active and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            irq_vec  <= 3'b000;
            active   <= SRC_NONE;
            busy     <= 1'b0;
            svc_cnt  <= 16'd0;
            hold_cnt <= 4'd0;
        end else begin
            irq_vec <= 3'b000;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state   <= ST_FIRE;
                        irq_vec <= src_onehot(win_idx);
                        active  <= win_idx;
                        busy    <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state   <= ST_SERVICE;
                    svc_cnt <= 16'd0;
                end
                ST_SERVICE: begin
                    if (eirq || (svc_cnt == SVC_LAST)) begin
                        active  <= SRC_NONE;
                        svc_cnt <= 16'd0;
                        if (HOLDOFF == 0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_HOLDOFF;
                            hold_cnt <= 4'd0;
                        end
                    end else begin
                        svc_cnt <= svc_cnt + 16'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        hold_cnt <= 4'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

`ifdef IRQ_OVERRUN_EN
    logic [2:0] overrun_set;

    assign overrun_set = src_req & (pending | src_onehot(active));

    // Sticky overrun flags; new overruns beat a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 3'b000;
        end else if (clr_err) begin
            overrun <= overrun_set;
        end else begin
            overrun <= overrun | overrun_set;
        end
    end
`else
    // Without overrun tracking, repeated requests merge silently in the
    // pending latch.
`endif

endmodule

// File: tb/tb_irq_dispatcher.sv
// Testbench for irq_dispatcher: directed scenarios with a dispatch
// scoreboard (expected irq pulses queued by the stimulus, popped by a
// monitor on every observed pulse) plus inline status checks.
module tb_irq_dispatcher;
    import cpu_pkg::*;

    typedef struct packed {
        logic [2:0] vec;
        logic [1:0] act;
    } disp_t;

    logic       clk;
    logic       rst;
    logic [2:0] src_req;
    logic       mask_wr;
    logic [2:0] mask_data;
    logic       clr_err;
    logic       eirq;
    logic       irq1, irq2, irq3;
    logic [2:0] pending;
    logic [1:0] active;
    logic       busy;
    logic       timeout_err;
`ifdef IRQ_OVERRUN_EN
    logic [2:0] overrun;
`endif

    int    checks;
    int    failures;
    disp_t exp_q[$];

    irq_dispatcher #(
        .TIMEOUT (8),
        .HOLDOFF (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .mask_wr     (mask_wr),
        .mask_data   (mask_data),
        .clr_err     (clr_err),
        .eirq        (eirq),
        .irq1        (irq1),
        .irq2        (irq2),
        .irq3        (irq3),
        .pending     (pending),
        .active      (active),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef IRQ_OVERRUN_EN
        ,
        .overrun     (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_disp(input logic [2:0] vec, input logic [1:0] act);
        disp_t d;
        d.vec = vec;
        d.act = act;
        exp_q.push_back(d);
    endtask

    // Finish a service: eirq for one cycle, then wait out the holdoff.
    task automatic end_service();
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: every cycle with an irq line high must match the next queued dispatch.
    always @(negedge clk) begin
        if ({irq3, irq2, irq1} != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_irq", {27'd0, irq3, irq2, irq1, active}, 32'd0);
            end else begin
                disp_t d;
                d = exp_q.pop_front();
                check("irq_vec", {29'd0, irq3, irq2, irq1}, {29'd0, d.vec});
                check("irq_active", {30'd0, active}, {30'd0, d.act});
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        src_req   = 3'b000;
        mask_wr   = 1'b0;
        mask_data = 3'b000;
        clr_err   = 1'b0;
        eirq      = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pending", {29'd0, pending}, 32'd0);
        check("rst_active", {30'd0, active}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, timeout_err}, 32'd0);
`ifdef IRQ_OVERRUN_EN
        check("rst_overrun", {29'd0, overrun}, 32'd0);
`endif
        rst = 1'b1;
        tick();
        eirq = 1'b1;                 // ignored outside SERVICE
        tick();
        eirq = 1'b0;
        check("eirq_idle_busy", {31'd0, busy}, 32'd0);

        // Single request on source 1 -> irq2 two edges later
        expect_disp(3'b010, SRC_2);
        src_req = 3'b010;
        tick();
        src_req = 3'b000;
        check("single_pend", {29'd0, pending}, 32'h2);
        check("single_lat_irq", {31'd0, irq2}, 32'd0);
        tick();
        check("single_irq2", {31'd0, irq2}, 32'd1);
        check("single_active", {30'd0, active}, 32'd2);
        check("single_busy", {31'd0, busy}, 32'd1);
        tick();
        check("single_pulse_end", {31'd0, irq2}, 32'd0);
        repeat (4) tick();
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        check("single_eoi_active", {30'd0, active}, 32'd0);
        check("single_hold_busy", {31'd0, busy}, 32'd1);
        tick();
        check("single_hold2_busy", {31'd0, busy}, 32'd1);
        tick();
        check("single_idle_busy", {31'd0, busy}, 32'd0);

        // Priority: bits 1 and 2 together
        expect_disp(3'b010, SRC_2);
        expect_disp(3'b100, SRC_3);
        src_req = 3'b110;
        tick();
        src_req = 3'b000;
        check("prio_pend0", {29'd0, pending}, 32'h6);
        tick();
        check("prio_pend1", {29'd0, pending}, 32'h4);
        tick();
        end_service();
        tick();
        check("prio_active3", {30'd0, active}, 32'd3);
        check("prio_pend2", {29'd0, pending}, 32'h0);
        tick();
        end_service();

        // Mask: source 0 masked, latched but not dispatched
        mask_wr   = 1'b1;
        mask_data = 3'b110;
        tick();
        mask_wr = 1'b0;
        src_req = 3'b001;
        tick();
        src_req = 3'b000;
        repeat (3) tick();
        check("mask_pend", {29'd0, pending}, 32'h1);
        check("mask_busy", {31'd0, busy}, 32'd0);
        expect_disp(3'b001, SRC_1);
        mask_wr   = 1'b1;
        mask_data = 3'b111;
        tick();
        mask_wr = 1'b0;
        check("mask_old_used", {31'd0, busy}, 32'd0);
        tick();
        check("mask_irq1", {31'd0, irq1}, 32'd1);
        check("mask_pend0", {29'd0, pending}, 32'h0);
        tick();
        end_service();

        // Timeout with a simultaneous clr_err (set wins)
        expect_disp(3'b001, SRC_1);
        src_req = 3'b001;
        tick();
        src_req = 3'b000;
        tick();
        repeat (8) tick();
        check("to_before_err", {31'd0, timeout_err}, 32'd0);
        check("to_before_busy", {31'd0, busy}, 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("to_err_set", {31'd0, timeout_err}, 32'd1);
        check("to_active", {30'd0, active}, 32'd0);
        tick();
        tick();
        check("to_idle", {31'd0, busy}, 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("to_err_clr", {31'd0, timeout_err}, 32'd0);

        // eirq in the timeout cycle is a normal end
        expect_disp(3'b001, SRC_1);
        src_req = 3'b001;
        tick();
        src_req = 3'b000;
        tick();
        repeat (8) tick();
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        check("to_eirq_err", {31'd0, timeout_err}, 32'd0);
        check("to_eirq_active", {30'd0, active}, 32'd0);
        tick();
        tick();

        // Merge: three requests on source 0 while irq3 is in service
        expect_disp(3'b100, SRC_3);
        expect_disp(3'b001, SRC_1);
        src_req = 3'b100;
        tick();
        src_req = 3'b000;
        tick();
        tick();
        repeat (3) begin
            src_req = 3'b001;
            tick();
            src_req = 3'b000;
            tick();
        end
        check("merge_pend", {29'd0, pending}, 32'h1);
`ifdef IRQ_OVERRUN_EN
        check("merge_overrun", {29'd0, overrun}, 32'h1);
`endif
        end_service();
        tick();
        check("merge_irq1", {31'd0, irq1}, 32'd1);
        check("merge_pend0", {29'd0, pending}, 32'h0);
        tick();
        end_service();

        // Reset mid-service with a masked pending request
        expect_disp(3'b010, SRC_2);
        src_req = 3'b010;
        tick();
        src_req = 3'b000;
        tick();
        tick();
        mask_wr   = 1'b1;
        mask_data = 3'b011;
        src_req   = 3'b100;
        tick();
        mask_wr = 1'b0;
        src_req = 3'b000;
        rst = 1'b0;
        #2;
        check("mid_rst_active", {30'd0, active}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_pend", {29'd0, pending}, 32'd0);
        check("mid_rst_irq", {29'd0, irq3, irq2, irq1}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        expect_disp(3'b100, SRC_3);
        src_req = 3'b100;
        tick();
        src_req = 3'b000;
        tick();
        check("post_rst_mask_irq3", {31'd0, irq3}, 32'd1);
        tick();
        end_service();
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
